seq_shift_unit: RTL and testbench
=================================

# seq_shift_unit

Parametrised multi-cycle shift unit. Holds a WIDTH-bit register that can be parallel-loaded, then shifted by a requested amount at one position per clock in a selectable mode. It uses a start/busy/done handshake and sits between a controller and a datapath in the same role as the fixed 8-bit shift register, generalised in width, direction and shift count.

## Interface
- WIDTH, 8, register width; legal range WIDTH >= 2
- AW, 4, width of the amount field; amounts 0 .. 2^AW-1 are legal

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- load_val  in  WIDTH  parallel load value
- load_n  in  1  active-low synchronous parallel load
- start  in  1  begin a shift operation; sampled in IDLE only
- mode  in  2  shift mode: 00 LSR, 01 ASR, 10 LSL, 11 ROR (see Configuration)
- amount  in  AW  number of single-position shifts to perform
- Q  out  WIDTH  register contents
- shift_out  out  1  bit shifted out by the most recent shift
- busy  out  1  high while a shift operation is in progress
- done  out  1  one-cycle pulse when an operation completes

## Operation
- States: IDLE and SHIFT. A down-counter cnt (AW bits) tracks the remaining shifts. The mode is latched at start.
- Reset (asynchronous, reset_n=0): Q=0, shift_out=0, busy=0, done=0, cnt=0, state=IDLE. This takes effect immediately, with no clock edge needed.
- IDLE, load_n=0: Q<=load_val and shift_out<=0. Load has priority over start, and start is ignored that cycle.
- IDLE, start=1, load_n=1:
  - amount=0: no shift. done<=1, Q unchanged, stay in IDLE, busy stays 0.
  - amount>0: latch mode, cnt<=amount, busy<=1, go to SHIFT.
- SHIFT, each edge: perform one shift and decrement cnt.
  - If cnt was 1: go to IDLE, busy<=0, done<=1.
- Shift definitions (one position):
  - LSR: Q<={0,Q[W-1:1]}, out=Q[0]
  - ASR: Q<={Q[W-1],Q[W-1:1]}, out=Q[0]
  - LSL: Q<={Q[W-2:0],0}, out=Q[W-1]
  - ROR: Q<={Q[0],Q[W-1:1]}, out=Q[0]
- Amounts above WIDTH are not clamped. The unit performs exactly `amount` shifts:
  - logical modes reach all zeros
  - ASR reaches full sign fill
  - ROR wraps modulo WIDTH
- SHIFT with load_n=0: abort. Q<=load_val, shift_out<=0, busy<=0, go to IDLE, no done pulse.
- SHIFT with start=1: ignored. mode and amount inputs are ignored while busy.
- done is high for exactly one cycle per completed operation and is cleared on the following edge.

## Timing
- start is sampled at edge T0.
- Shifts occur at edges T1..Tn, where n=amount. Q is updated after each of these edges.
- busy is high from after T0 until after Tn. done is high during the cycle following Tn.
- Latency from start to done is n+1 edges. With amount=0, done is high during the cycle after T0.
- Back-to-back: a new start may be sampled in the cycle where done=1, because the state is already IDLE.
- Load takes effect one edge after load_n is sampled low.

## Configuration
- SEQ_SHIFT_UNIT_ROTATE_EN:
  - Defined: mode 11 performs ROR as specified.
  - Undefined: no rotate logic is built, and mode 11 behaves exactly as LSR.

## Test plan
- WIDTH=8: load 0xB4, then start ASR with amount=3. Required: busy for 3 cycles, Q=0xDA, 0xED, then 0xF6, done pulse after the third shift, shift_out=1.
- Load 0x81, then LSL with amount=1. Required: Q=0x02, shift_out=1, done 2 edges after start, busy high for 1 cycle.
- Load 0x5A, then start with amount=0. Required: busy stays 0, done pulses the cycle after start, Q stays 0x5A.
- Load 0x01, then mode 11 with amount=9:
  - With SEQ_SHIFT_UNIT_ROTATE_EN: Q=0x80, shift_out=1.
  - Without it: Q=0x00, shift_out=0.
- Load 0xFF, start LSR with amount=5, then drive load_n=0 with load_val=0x3C after the 2nd shift. Required: Q=0x3C, busy=0, no done pulse, shift_out=0.
- Start LSL with amount=6, then assert reset_n=0 between clock edges after the 2nd shift. Required: Q=0, busy=0, done=0 immediately; after release, IDLE and accepts a new start.

Source files
------------

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit: parallel load, then one shift per clock with a start/busy/done handshake.
// Define SEQ_SHIFT_UNIT_ROTATE_EN to build rotate-right for mode 11; otherwise mode 11 acts as LSR.
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    amount,
  output logic [WIDTH-1:0] Q,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic             shiftOut_q;
  logic             busy_q;
  logic             done_q;
  logic [AW-1:0]    cnt_q;
  logic [1:0]       mode_q;

  logic [WIDTH-1:0] data_d;
  logic             shiftOut_d;

  // Single-position shift of the current register using the mode latched at start.
  always_comb begin
    data_d     = {1'b0, data_q[WIDTH-1:1]};
    shiftOut_d = data_q[0];
    case (mode_q)
      2'b00: data_d = {1'b0, data_q[WIDTH-1:1]};
      2'b01: data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      2'b10: begin
        data_d     = {data_q[WIDTH-2:0], 1'b0};
        shiftOut_d = data_q[WIDTH-1];
      end
      default: begin
`ifdef SEQ_SHIFT_UNIT_ROTATE_EN
        data_d = {data_q[0], data_q[WIDTH-1:1]};
`else
        data_d = {1'b0, data_q[WIDTH-1:1]};
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      shiftOut_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= 2'b00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!load_n) begin
            data_q     <= load_val;
            shiftOut_q <= 1'b0;
          end else if (start) begin
            if (amount == '0) begin
              done_q <= 1'b1;
            end else begin
              mode_q  <= mode;
              cnt_q   <= amount;
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          // A load during a shift aborts the operation without a done pulse.
          if (!load_n) begin
            data_q     <= load_val;
            shiftOut_q <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end else begin
            data_q     <= data_d;
            shiftOut_q <= shiftOut_d;
            cnt_q      <= cnt_q - 1'b1;
            if (cnt_q == AW'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q         = data_q;
  assign shift_out = shiftOut_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: expected results are queued at start and checked by a
// monitor on each done pulse; aborts and resets are checked inline.
module tb_seq_shift_unit;

  localparam int WIDTH = 8;
  localparam int AW    = 4;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] load_val;
  logic             load_n;
  logic             start;
  logic [1:0]       mode;
  logic [AW-1:0]    amount;
  logic [WIDTH-1:0] Q;
  logic             shift_out;
  logic             busy;
  logic             done;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [WIDTH-1:0] sbQ[$];
  logic             sbSo[$];
  string            sbName[$];
  logic [WIDTH-1:0] traceQ[$];

  seq_shift_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_val (load_val),
    .load_n   (load_n),
    .start    (start),
    .mode     (mode),
    .amount   (amount),
    .Q        (Q),
    .shift_out(shift_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected done", int'(done), 0);
      end else begin
        string nm;
        nm = sbName.pop_front();
        checkOutput({nm, " Q"}, int'(Q), int'(sbQ.pop_front()));
        checkOutput({nm, " shift_out"}, int'(shift_out), int'(sbSo.pop_front()));
        checkOutput({nm, " busy at done"}, int'(busy), 0);
      end
    end
  end

  task automatic doLoad(input logic [WIDTH-1:0] v);
    load_n   = 1'b0;
    load_val = v;
    @(negedge clk);
    load_n = 1'b1;
    checkOutput("load Q", int'(Q), int'(v));
    checkOutput("load shift_out", int'(shift_out), 0);
  endtask

  // Issues a start, then counts busy cycles and edges until done, within a bounded budget.
  task automatic applyStimulus(input string nm, input logic [1:0] m, input logic [AW-1:0] amt,
                               input logic [WIDTH-1:0] expQ, input logic expSo, input int expBusy);
    int edges;
    int busyCnt;
    bit seen;
    sbQ.push_back(expQ);
    sbSo.push_back(expSo);
    sbName.push_back(nm);
    start   = 1'b1;
    mode    = m;
    amount  = amt;
    edges   = 0;
    busyCnt = 0;
    seen    = 1'b0;
    while (!seen && edges < 40) begin
      @(negedge clk);
      start = 1'b0;
      edges++;
      if (busy) busyCnt++;
      if (traceQ.size() > 0) checkOutput({nm, " trace Q"}, int'(Q), int'(traceQ.pop_front()));
      if (done) seen = 1'b1;
    end
    checkOutput({nm, " latency"}, edges, int'(amt) + 1);
    checkOutput({nm, " busy cycles"}, busyCnt, expBusy);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    load_n   = 1'b1;
    load_val = '0;
    start    = 1'b0;
    mode     = 2'b00;
    amount   = '0;
    #1;
    checkOutput("reset Q", int'(Q), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset shift_out", int'(shift_out), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ASR of 0xB4 by 3 with intermediate values
    doLoad(8'hB4);
    traceQ.push_back(8'hB4);
    traceQ.push_back(8'hDA);
    traceQ.push_back(8'hED);
    traceQ.push_back(8'hF6);
    applyStimulus("asr3", 2'b01, 4'd3, 8'hF6, 1'b1, 3);

    // Loaded back-to-back in the done cycle
    doLoad(8'h81);
    applyStimulus("lsl1", 2'b10, 4'd1, 8'h02, 1'b1, 1);

    doLoad(8'h5A);
    applyStimulus("amt0", 2'b00, 4'd0, 8'h5A, 1'b0, 0);

    doLoad(8'h01);
`ifdef SEQ_SHIFT_UNIT_ROTATE_EN
    applyStimulus("mode11 amt9", 2'b11, 4'd9, 8'h80, 1'b1, 9);
`else
    applyStimulus("mode11 amt9", 2'b11, 4'd9, 8'h00, 1'b0, 9);
`endif

    doLoad(8'hA5);
    applyStimulus("lsr15", 2'b00, 4'd15, 8'h00, 1'b0, 15);

    // Abort by load after the second shift
    doLoad(8'hFF);
    start  = 1'b1;
    mode   = 2'b00;
    amount = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("abort shift1 Q", int'(Q), 8'h7F);
    @(negedge clk);
    checkOutput("abort shift2 Q", int'(Q), 8'h3F);
    load_n   = 1'b0;
    load_val = 8'h3C;
    @(negedge clk);
    load_n = 1'b1;
    checkOutput("abort Q", int'(Q), 8'h3C);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort shift_out", int'(shift_out), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post-abort done", int'(done), 0);
      checkOutput("post-abort Q", int'(Q), 8'h3C);
    end

    // Asynchronous reset mid-operation
    doLoad(8'h0F);
    start  = 1'b1;
    mode   = 2'b10;
    amount = 4'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre-reset Q", int'(Q), 8'h3C);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset Q", int'(Q), 0);
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset done", int'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("after reset busy", int'(busy), 0);
    doLoad(8'h0C);
    applyStimulus("post-reset lsr2", 2'b00, 4'd2, 8'h03, 1'b0, 2);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
